// File: rtl/pcm_pkg.sv
// rtl/pcm_pkg.sv - shared PCM constants, DC-block FSM states and saturation helper
//
// Purpose: common definitions for the PCM back-end (DC blocker, serializer).
//   PCM_W      default PCM sample width
//   DC_K       default DC-block pole shift (alpha = 1 - 2^-K)
//   dc_state_t DC-block sequencing states
//   sat_w      clamp a signed 64-bit value to a signed w-bit range
package pcm_pkg;

  localparam int PCM_W = 16;
  localparam int DC_K  = 4;

  typedef enum logic [1:0] {
    IDLE,
    DIFF,
    ACC,
    OUT
  } dc_state_t;

  // Result is still 64 bits wide; the caller truncates to w bits, which is
  // lossless once the value has been clamped.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pcm_edge_sync.sv
// rtl/pcm_edge_sync.sv - 2-FF synchronizer with rising-edge strobe
//
// Purpose: bring an asynchronous clock-like signal into the clk domain and
// emit one clk-wide pulse per rising edge.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset (clears all stages)
//   async_in asynchronous input
//   strobe   one-cycle pulse, high while sync2 & ~sync3
module pcm_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic strobe
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // sync3 is the edge-detect history register, not a metastability stage.
  assign strobe = sync2 & ~sync3;

endmodule

// File: rtl/pcm_dc_block.sv
// rtl/pcm_dc_block.sv - shift-only first-order DC-blocking high-pass with valid/ready output
//
// Purpose: samples the decimator PCM word on each clk_pcm rising edge and
// computes y[n] = x[n] - x[n-1] + (1 - 2^-K) * y[n-1], presenting y on a
// valid/ready interface.
// Configuration macro: PCM_DC_BLOCK_SAT_EN
//   defined   -> output clamps to the signed W-bit range
//   undefined -> output is the low W bits (two's-complement wrap)
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   clk_pcm    decimator output-rate clock (asynchronous to clk)
//   din        signed PCM input, stable >= 4 clk after each clk_pcm rise
//   dout       signed filtered sample
//   dout_valid dout holds an unconsumed sample
//   dout_ready consumer accepts dout when dout_valid && dout_ready
//   overrun    sticky: a new sample replaced an unconsumed one
module pcm_dc_block
  import pcm_pkg::*;
#(
  parameter int W = PCM_W,
  parameter int K = DC_K
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_pcm,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                overrun
);

  // acc holds y scaled by 2^K, plus headroom for the full-scale difference.
  localparam int ACC_W = W + K + 2;

  logic                    strobe;
  dc_state_t               state;
  logic signed [W-1:0]     x;
  logic signed [W-1:0]     x_prev;
  logic signed [W:0]       d;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] d_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [W-1:0]     dout_w;

  pcm_edge_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (clk_pcm),
    .strobe   (strobe)
  );

  assign d_ext    = {{(ACC_W-W-1){d[W]}}, d};
  assign acc_next = acc - (acc >>> K) + (d_ext <<< K);

  // acc already holds the updated value by the time the FSM reaches OUT.
`ifdef PCM_DC_BLOCK_SAT_EN
  assign dout_w = W'(sat_w($signed({{(64-ACC_W){acc[ACC_W-1]}}, acc}) >>> K, W));
`else
  assign dout_w = acc[K+W-1:K];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x          <= '0;
      x_prev     <= '0;
      d          <= '0;
      acc        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (dout_valid && dout_ready) dout_valid <= 1'b0;

      // A strobe outside IDLE is silently dropped.
      case (state)
        IDLE: begin
          if (strobe) begin
            x     <= din;
            state <= DIFF;
          end
        end
        DIFF: begin
          d      <= {x[W-1], x} - {x_prev[W-1], x_prev};
          x_prev <= x;
          state  <= ACC;
        end
        ACC: begin
          acc   <= acc_next;
          state <= OUT;
        end
        OUT: begin
          dout       <= dout_w;
          dout_valid <= 1'b1;
          if (dout_valid && !dout_ready) overrun <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_dc_block.sv
// tb/tb_pcm_dc_block.sv - scoreboard testbench for pcm_dc_block
module tb_pcm_dc_block;

  localparam int W = 16;
  localparam int K = 4;

`ifdef PCM_DC_BLOCK_SAT_EN
  localparam int SAT2_EXP = 32767;
`else
  localparam int SAT2_EXP = -30721;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                clk_pcm;
  logic signed [W-1:0] din;
  logic signed [W-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;
  logic                overrun;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  longint m_acc;
  longint m_xp;

  pcm_dc_block #(.W(W), .K(K)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_pcm    (clk_pcm),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_acc = 0;
    m_xp  = 0;
  endfunction

  function automatic int model_step(input int xin);
    longint dd;
    longint y;
    logic signed [15:0] y16;
    dd    = longint'(xin) - m_xp;
    m_xp  = xin;
    m_acc = m_acc - (m_acc >>> K) + (dd <<< K);
    y     = m_acc >>> K;
`ifdef PCM_DC_BLOCK_SAT_EN
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
`endif
    y16 = y[15:0];
    return int'(y16);
  endfunction

  // Monitor: a transfer happens at the posedge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (!reset && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0d required=none", int'(dout));
      end else begin
        check("scoreboard", int'(dout), exp_q.pop_front());
      end
    end
  end

  // One clk_pcm period (10 clk). Optional: measure edge-to-valid latency,
  // raise dout_ready after posedge ready_at, pulse reset after posedge reset_at.
  task automatic send(input int value, input bit push, input int exp_val,
                      input bit measure, input int ready_at, input int reset_at);
    int lat;
    lat = 0;
    @(negedge clk);
    din     = W'(value);
    clk_pcm = 1'b1;
    if (push) exp_q.push_back(exp_val);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (measure && lat == 0 && dout_valid) lat = i;
      if (ready_at > 0 && i == ready_at + 1) begin
        check("coincident_valid", int'(dout_valid), 1);
        check("coincident_dout", int'(dout), exp_val);
        check("coincident_overrun", int'(overrun), 0);
      end
      if (ready_at > 0 && i == ready_at) dout_ready = 1'b1;
      if (reset_at > 0 && i == reset_at + 1) begin
        reset = 1'b0;
        check("midreset_dout", int'(dout), 0);
        check("midreset_valid", int'(dout_valid), 0);
        check("midreset_overrun", int'(overrun), 0);
      end
      if (reset_at > 0 && i == reset_at) reset = 1'b1;
      if (i == 4) clk_pcm = 1'b0;
    end
    if (measure) check("latency", lat, 6);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset      = 1'b1;
    clk_pcm    = 1'b0;
    din        = '0;
    dout_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", int'(dout), 0);
    check("reset_valid", int'(dout_valid), 0);
    check("reset_overrun", int'(overrun), 0);
    reset = 1'b0;

    // Zero input
    dout_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(0, 1'b1, model_step(0), i == 0, 0, 0);
    check("zero_overrun", int'(overrun), 0);

    // DC step 0 -> 1000, decaying toward zero
    send(1000, 1'b1, 1000, 1'b1, 0, 0);
    send(1000, 1'b1, 937, 1'b1, 0, 0);
    send(1000, 1'b1, 878, 1'b1, 0, 0);
    for (int i = 0; i < 3; i++) void'(model_step(1000));
    for (int i = 0; i < 197; i++) send(1000, 1'b1, model_step(1000), 1'b0, 0, 0);
    check("step_settled", int'(dout), 0);
    check("step_overrun", int'(overrun), 0);

    // Full-scale swing: wrap or clamp
    do_reset();
    send(-32768, 1'b1, -32768, 1'b0, 0, 0);
    send(32767, 1'b1, SAT2_EXP, 1'b0, 0, 0);

    // Ready coincident with OUT
    do_reset();
    dout_ready = 1'b0;
    send(100, 1'b1, 100, 1'b0, 0, 0);
    send(100, 1'b1, 93, 1'b0, 5, 0);

    // Backpressure across two samples
    dout_ready = 1'b0;
    send(100, 1'b0, 0, 1'b0, 0, 0);
    send(100, 1'b1, 82, 1'b0, 0, 0);
    check("bp_overrun", int'(overrun), 1);
    check("bp_dout", int'(dout), 82);
    check("bp_valid", int'(dout_valid), 1);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_cleared", int'(dout_valid), 0);
    check("bp_overrun_sticky", int'(overrun), 1);

    // Reset during ACC aborts the sample and clears filter state
    send(500, 1'b1, 477, 1'b0, 0, 0);
    send(-200, 1'b0, 0, 1'b0, 0, 4);
    send(1000, 1'b1, 1000, 1'b1, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
